completer_node: RTL
===================

// Module: completer_node
// PURPOSE
//  Far end of the RN->CN request path: accepts request flits from four request nodes over the ICN,
//  round-robin arbitrates, replays the winner as an APB master transfer to one completer, and
//  returns {pready,prdata,pslverr} as a response flit on the winner's rxrsp port. One CN per completer.
// PARAMETERS
//  ADDR_WIDTH      `ADDR_WIDTH      APB address width
//  DATA_WIDTH      `DATA_WIDTH      APB data width (multiple of 8)
//  REQ_FLIT_WIDTH  `REQ_FLIT_WIDTH  ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8+8
//  RSP_FLIT_WIDTH  `RSP_FLIT_WIDTH  DATA_WIDTH+2
//  TIMEOUT_CYCLES  256              ACCESS-state cycle limit (only with CN_TIMEOUT_EN)
// PORTS
//  pclk          in   1               clock
//  preset_n      in   1               reset; asynchronous, active-low
//  rn_valid      in   4               bit i: RN i+1 presents a request to this CN
//  cn_ready      out  4               bit i: flit on icn_txreq_(i+1) captured this cycle
//  icn_txreq_1..4 in  REQ_FLIT_WIDTH  {paddr,pprot,pnse,psel,penable,pwrite,pwdata,pstrb,pwakeup}
//  icn_rxrsp_1..4 out RSP_FLIT_WIDTH  {pready,prdata,pslverr}
//  paddr/pprot/pnse/pwrite/pwdata/pstrb/pwakeup  out  per APB4/5  from latched flit
//  psel, penable out  1               APB master controls
//  pready        in   1               completer ready
//  prdata        in   DATA_WIDTH      completer read data
//  pslverr       in   1               completer error
// BEHAVIOUR
//  - Reset: state=IDLE; rr pointer=RN1; cn_ready=0; psel=penable=0; all APB outs 0; all rxrsp=0.
//  - FSM IDLE->SETUP->ACCESS->RESP->IDLE.
//  - IDLE: if |rn_valid, arbiter grants one RN; cn_ready[g]=1 combinationally this cycle
//    (=(state==IDLE)&grant[g]); flit latched at this edge; ->SETUP. No valid: stay, cn_ready=0.
//  - Round robin: search starts at bit after last winner, wraps 3->0; pointer updates on grant.
//  - SETUP (1 cycle): psel=1, penable=0, APB fields from latched flit; ->ACCESS.
//  - ACCESS: psel=1, penable=1; hold until pready=1; on pready latch prdata,pslverr; ->RESP.
//  - RESP (1 cycle): icn_rxrsp_g={1'b1,prdata_q,pslverr_q}; every other rxrsp=0; psel=penable=0.
//  - rxrsp ports are 0 outside RESP; pready field of flit is the RN's completion strobe.
//  - Latency: valid in cycle 0, zero-wait completer -> rxrsp in cycle 3; next grant cycle 4.
//  - Flit psel/penable bits ignored (CN regenerates phases); pwrite=0 forces pstrb=0 on APB.
//  - rn_valid dropping after grant has no effect; transfer runs to completion.
//  - Simultaneous valids: exactly one cn_ready bit high; losers wait, no starvation (<=3 waits).
//  - Async reset mid-transfer: psel/penable drop immediately, transfer lost, no response sent.
// CONFIGURATION
//  CN_TIMEOUT_EN defined: ACCESS counter; after TIMEOUT_CYCLES cycles without pready, abort ->
//    RESP with prdata=0, pslverr=1; psel dropped. Counter clears on entering ACCESS.
//  CN_TIMEOUT_EN undefined: ACCESS waits indefinitely; no counter logic; TIMEOUT_CYCLES unused.
// STRUCTURE
//  - define_file.sv: width macros plus new flit field offset macros (REQ_PADDR_MSB..., RSP_PREADY_BIT).
//  - Sub-module cn_arbiter: 4-way round-robin, inputs req[3:0], adv; outputs one-hot grant[3:0].
//  - Top holds FSM, flit register, response register, rxrsp demux, optional timeout counter.
// TESTING
//  1 rn_valid=4'b0010, write paddr=0x1000_0004 pwdata=0xA5A5_A5A5, pready=1 -> cn_ready=0010 cyc0,
//    psel cyc1-2, penable cyc2, icn_rxrsp_2={1,0,0} cyc3, other rxrsp 0.
//  2 Read, prdata=0xDEAD_BEEF, pready low 3 ACCESS cycles -> rxrsp={1,0xDEADBEEF,0} 3 cycles late.
//  3 rn_valid=4'b1111 held, 8 transfers -> grant order RN1,2,3,4,1,2,3,4.
//  4 pslverr=1 with pready -> rxrsp pslverr bit=1, next transfer unaffected.
//  5 preset_n low in ACCESS -> psel=penable=0 same cycle, no rxrsp, IDLE after release.
//  6 CN_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready=0 -> rxrsp={1,0,1} after 16 ACCESS cycles.

Source files
------------

// File: rtl/completer_node_pkg.sv
// Shared types and default widths for the completer node (CN) slice.
package completer_node_pkg;

  localparam int CN_ADDR_WIDTH = 32;
  localparam int CN_DATA_WIDTH = 32;
  localparam int NUM_RN        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } cn_state_e;

endpackage

// File: rtl/cn_arbiter.sv
// Four-way round-robin arbiter. The search starts at the RN after the last winner.
// The pointer advances only when a grant is taken (adv high).
module cn_arbiter
  import completer_node_pkg::*;
(
  input  logic              pclk,
  input  logic              preset_n,
  input  logic [NUM_RN-1:0] req,
  input  logic              adv,
  output logic [NUM_RN-1:0] grant
);

  logic [1:0] prio_q;
  logic [1:0] win_idx;
  logic       found;

  // The two-bit index sum wraps naturally from RN4 back to RN1.
  always_comb begin
    grant   = '0;
    win_idx = prio_q;
    found   = 1'b0;
    for (int k = 0; k < NUM_RN; k++) begin
      if (!found && req[prio_q + 2'(k)]) begin
        win_idx = prio_q + 2'(k);
        found   = 1'b1;
      end
    end
    if (found) grant[win_idx] = 1'b1;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prio_q <= 2'd0;
    end else if (adv && found) begin
      prio_q <= win_idx + 2'd1;
    end
  end

endmodule

// File: rtl/completer_node.sv
// Completer node: arbitrates four RN request flits, replays the winner as an APB
// transfer and returns the response flit. Define CN_TIMEOUT_EN for the ACCESS timeout.
module completer_node
  import completer_node_pkg::*;
#(
  parameter int ADDR_WIDTH     = CN_ADDR_WIDTH,
  parameter int DATA_WIDTH     = CN_DATA_WIDTH,
  parameter int REQ_FLIT_WIDTH = ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8 + 8,
  parameter int RSP_FLIT_WIDTH = DATA_WIDTH + 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_RN-1:0]         rn_valid,
  output logic [NUM_RN-1:0]         cn_ready,
  input  logic [REQ_FLIT_WIDTH-1:0] icn_txreq_1,
  input  logic [REQ_FLIT_WIDTH-1:0] icn_txreq_2,
  input  logic [REQ_FLIT_WIDTH-1:0] icn_txreq_3,
  input  logic [REQ_FLIT_WIDTH-1:0] icn_txreq_4,
  output logic [RSP_FLIT_WIDTH-1:0] icn_rxrsp_1,
  output logic [RSP_FLIT_WIDTH-1:0] icn_rxrsp_2,
  output logic [RSP_FLIT_WIDTH-1:0] icn_rxrsp_3,
  output logic [RSP_FLIT_WIDTH-1:0] icn_rxrsp_4,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [2:0]                pprot,
  output logic                      pnse,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic                      pwakeup,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  cn_state_e state_q, state_d;

  logic [NUM_RN-1:0]         grant;
  logic [NUM_RN-1:0]         winner_q;
  logic [REQ_FLIT_WIDTH-1:0] txreq [NUM_RN];
  logic [REQ_FLIT_WIDTH-1:0] sel_flit;
  logic                      take_req;
  logic                      timeout_hit;
  logic                      rsp_active;
  logic [RSP_FLIT_WIDTH-1:0] rsp_flit;

  logic [ADDR_WIDTH-1:0]   f_addr;
  logic [2:0]              f_prot;
  logic                    f_nse, f_psel, f_penable, f_write, f_wake;
  logic [DATA_WIDTH-1:0]   f_wdata;
  logic [DATA_WIDTH/8-1:0] f_strb;
  logic                    unused_phase_bits;

  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic                    pnse_q, pwrite_q, pwakeup_q, pslverr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q, prdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;

  assign txreq[0] = icn_txreq_1;
  assign txreq[1] = icn_txreq_2;
  assign txreq[2] = icn_txreq_3;
  assign txreq[3] = icn_txreq_4;

  assign take_req = (state_q == ST_IDLE) && (|rn_valid);
  assign cn_ready = (state_q == ST_IDLE) ? grant : '0;

  cn_arbiter u_arbiter (
    .pclk     (pclk),
    .preset_n (preset_n),
    .req      (rn_valid),
    .adv      (state_q == ST_IDLE),
    .grant    (grant)
  );

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NUM_RN; i++) begin
      if (grant[i]) sel_flit = txreq[i];
    end
  end

  // The flit's own psel/penable bits are dropped; the CN regenerates the phases.
  assign {f_addr, f_prot, f_nse, f_psel, f_penable, f_write, f_wdata, f_strb, f_wake} = sel_flit;
  assign unused_phase_bits = f_psel ^ f_penable;

`ifdef CN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      to_cnt <= '0;
    end else if (state_q == ST_SETUP) begin
      to_cnt <= '0;
    end else if (state_q == ST_ACCESS) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state_q == ST_ACCESS) && !pready && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|rn_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    psel       = 1'b0;
    penable    = 1'b0;
    rsp_active = 1'b0;
    case (state_q)
      ST_SETUP:  psel = 1'b1;
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      ST_RESP:   rsp_active = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      winner_q  <= '0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pnse_q    <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pwakeup_q <= 1'b0;
    end else if (take_req) begin
      winner_q  <= grant;
      paddr_q   <= f_addr;
      pprot_q   <= f_prot;
      pnse_q    <= f_nse;
      pwrite_q  <= f_write;
      pwdata_q  <= f_wdata;
      pstrb_q   <= f_strb;
      pwakeup_q <= f_wake;
    end
  end

  // A timeout abort reports as an error response with zero data.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      if (pready) begin
        prdata_q  <= prdata;
        pslverr_q <= pslverr;
      end else if (timeout_hit) begin
        prdata_q  <= '0;
        pslverr_q <= 1'b1;
      end
    end
  end

  assign paddr   = paddr_q;
  assign pprot   = pprot_q;
  assign pnse    = pnse_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pwrite_q ? pstrb_q : '0;
  assign pwakeup = pwakeup_q;

  assign rsp_flit    = {1'b1, prdata_q, pslverr_q};
  assign icn_rxrsp_1 = (rsp_active && winner_q[0]) ? rsp_flit : '0;
  assign icn_rxrsp_2 = (rsp_active && winner_q[1]) ? rsp_flit : '0;
  assign icn_rxrsp_3 = (rsp_active && winner_q[2]) ? rsp_flit : '0;
  assign icn_rxrsp_4 = (rsp_active && winner_q[3]) ? rsp_flit : '0;

endmodule
